fft_stage_stream: RTL and testbench

Streaming, self-contained radix-2 DIT FFT stage with sample-serial valid/ready I/O and parametrised size, stage index and fixed-point format. It buffers one frame of N_SAMPLES complex samples, computes all N_SAMPLES/2 butterflies of stage STAGE_FFT one per cycle against a caller-supplied sine table, then drains the frame in index order. It is the serial-interface successor of the packed-frame stage harness, so cascaded stages can be chained with one-sample-wide links.

---
 rtl/fft_stage_stream.sv | 185 ++++++++++++++++++
 tb/tb_fft_stage_stream.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_stream.sv
// Radix-2 DIT FFT stage: buffers one frame, runs N/2 in-place butterflies for STAGE_FFT, drains in index order.
// Latency: last input accepted at edge T, first output valid in cycle T+N/2+1; frame period N + N/2 + N cycles.
// Backpressure: send_msg and the read index hold while send_val && !send_rdy; recv_rdy is low outside LOAD.
module fft_stage_stream #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8,
  parameter int STAGE_FFT  = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [2*BIT_WIDTH-1:0]          recv_msg,
  input  logic                            recv_val,
  output logic                            recv_rdy,
  output logic [2*BIT_WIDTH-1:0]          send_msg,
  output logic                            send_val,
  input  logic                            send_rdy,
  input  logic [N_SAMPLES*BIT_WIDTH-1:0]  sine_wave_in
);

  localparam int IW = $clog2(N_SAMPLES);

  // Index bookkeeping: frame indices and butterfly counter share one width.
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_SAMPLES - 1);
  localparam logic [IW-1:0] LAST_BFLY = IW'(N_SAMPLES / 2 - 1);
  // Butterfly span m = 2^s and mask for the position k inside a group.
  localparam logic [IW-1:0] SPAN      = IW'(1 << STAGE_FFT);
  localparam logic [IW-1:0] K_MASK    = IW'((1 << STAGE_FFT) - 1);
  // Twiddle stride N/(2m) is a power of two, so t = k << (log2(N) - 1 - s).
  localparam int            TW_SHIFT  = IW - 1 - STAGE_FFT;
  // cos(x) = sin(x + pi/2): a quarter-table offset, wrapping modulo N.
  localparam logic [IW-1:0] QUARTER   = IW'(N_SAMPLES / 4);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [IW-1:0] wr_q, wr_d;
  logic [IW-1:0] bf_q, bf_d;
  logic [IW-1:0] rd_q, rd_d;

  // Frame buffer; contents are meaningless after reset, so it carries no reset.
  logic [2*BIT_WIDTH-1:0] frame_q [N_SAMPLES];

  logic load_fire;
  logic bf_fire;

  // Butterfly datapath signals.
  logic [IW-1:0]          bf_k;
  logic [IW-1:0]          bf_top;
  logic [IW-1:0]          bf_bot;
  logic [IW-1:0]          tw_sin_idx;
  logic [IW-1:0]          tw_cos_idx;
  logic [BIT_WIDTH-1:0]   tw_sin;
  logic [BIT_WIDTH-1:0]   tw_cos;
  logic [2*BIT_WIDTH-1:0] top_val;
  logic [2*BIT_WIDTH-1:0] bot_val;
  logic [BIT_WIDTH-1:0]   a_re, a_im;
  logic [BIT_WIDTH-1:0]   b_re, b_im;
  logic [BIT_WIDTH-1:0]   p_re, p_im;
  logic [2*BIT_WIDTH-1:0] new_top;
  logic [2*BIT_WIDTH-1:0] new_bot;

  // Fixed-point multiply: full-width signed product, floor shift by the
  // fraction width, keep the low BIT_WIDTH bits (wraps, no saturation).
  function automatic logic [BIT_WIDTH-1:0] fx_mul(input logic [BIT_WIDTH-1:0] a,
                                                  input logic [BIT_WIDTH-1:0] b);
    logic signed [2*BIT_WIDTH-1:0] a_ext;
    logic signed [2*BIT_WIDTH-1:0] b_ext;
    a_ext = {{BIT_WIDTH{a[BIT_WIDTH-1]}}, a};
    b_ext = {{BIT_WIDTH{b[BIT_WIDTH-1]}}, b};
    return BIT_WIDTH'((a_ext * b_ext) >>> DECIMAL_PT);
  endfunction

  // Butterfly address generation, twiddle lookup and complex arithmetic for butterfly bf_q.
  always_comb begin
    bf_k       = bf_q & K_MASK;
    bf_top     = ((bf_q >> STAGE_FFT) << (STAGE_FFT + 1)) | bf_k;
    bf_bot     = bf_top + SPAN;
    tw_sin_idx = bf_k << TW_SHIFT;
    tw_cos_idx = tw_sin_idx + QUARTER;
    tw_sin     = sine_wave_in[tw_sin_idx * BIT_WIDTH +: BIT_WIDTH];
    tw_cos     = sine_wave_in[tw_cos_idx * BIT_WIDTH +: BIT_WIDTH];

    top_val = frame_q[bf_top];
    bot_val = frame_q[bf_bot];
    a_re    = top_val[2*BIT_WIDTH-1:BIT_WIDTH];
    a_im    = top_val[BIT_WIDTH-1:0];
    b_re    = bot_val[2*BIT_WIDTH-1:BIT_WIDTH];
    b_im    = bot_val[BIT_WIDTH-1:0];

    // p = bot * (cos - j*sin); each real product is rounded on its own.
    p_re = fx_mul(b_re, tw_cos) + fx_mul(b_im, tw_sin);
    p_im = fx_mul(b_im, tw_cos) - fx_mul(b_re, tw_sin);

    new_top = {a_re + p_re, a_im + p_im};
    new_bot = {a_re - p_re, a_im - p_im};
  end

  // Next-state, index updates and handshake outputs; ready/valid depend on state (and reset) only.
  always_comb begin
    state_d   = state_q;
    wr_d      = wr_q;
    bf_d      = bf_q;
    rd_d      = rd_q;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    send_msg  = '0;
    load_fire = 1'b0;
    bf_fire   = 1'b0;

    case (state_q)
      LOAD: begin
        // Held low while reset is asserted so nothing looks accepted then.
        recv_rdy = !reset;
        if (recv_val && !reset) begin
          load_fire = 1'b1;
          if (wr_q == LAST_IDX) begin
            wr_d    = '0;
            state_d = COMPUTE;
          end else begin
            wr_d = wr_q + 1'b1;
          end
        end
      end

      COMPUTE: begin
        bf_fire = 1'b1;
        if (bf_q == LAST_BFLY) begin
          bf_d    = '0;
          state_d = DRAIN;
        end else begin
          bf_d = bf_q + 1'b1;
        end
      end

      DRAIN: begin
        send_val = 1'b1;
        send_msg = frame_q[rd_q];
        if (send_rdy) begin
          if (rd_q == LAST_IDX) begin
            rd_d    = '0;
            state_d = LOAD;
          end else begin
            rd_d = rd_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State and index registers; reset discards any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LOAD;
      wr_q    <= '0;
      bf_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      bf_q    <= bf_d;
      rd_q    <= rd_d;
    end
  end

  // Frame buffer writes: incoming samples in LOAD, in-place butterfly results in COMPUTE.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      frame_q[wr_q] <= recv_msg;
    end
    if (bf_fire) begin
      frame_q[bf_top] <= new_top;
      frame_q[bf_bot] <= new_bot;
    end
  end

endmodule

// File: tb/tb_fft_stage_stream.sv
// Bench for fft_stage_stream: two N=8 stages (s=0, s=2) share one input port
// and are checked against hand-computed frames; a four-stage N=16 cascade is
// run with random handshakes against a fixed-point reference.
module tb_fft_stage_stream;

  localparam int BW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Shared stimulus for the two N=8 instances.
  logic [63:0] in_msg;
  logic        in_val;
  logic        send_rdy;
  logic        rdy_a, rdy_b, val_a, val_b;
  logic [63:0] msg_a, msg_b;
  logic [8*BW-1:0]  sine8;
  logic [16*BW-1:0] sine16;

  int n_chk  = 0;
  int n_fail = 0;

  fft_stage_stream #(.BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(8), .STAGE_FFT(0)) u_s0 (
    .clk(clk), .reset(rst), .recv_msg(in_msg), .recv_val(in_val), .recv_rdy(rdy_a),
    .send_msg(msg_a), .send_val(val_a), .send_rdy(send_rdy), .sine_wave_in(sine8));

  fft_stage_stream #(.BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(8), .STAGE_FFT(2)) u_s2 (
    .clk(clk), .reset(rst), .recv_msg(in_msg), .recv_val(in_val), .recv_rdy(rdy_b),
    .send_msg(msg_b), .send_val(val_b), .send_rdy(send_rdy), .sine_wave_in(sine8));

  // N=16 cascade: stage 0 -> 1 -> 2 -> 3.
  logic [63:0] c_in_msg, c_out_msg;
  logic        c_in_val, c_in_rdy, c_out_val, c_out_rdy;
  logic [63:0] lk_msg [5];
  logic        lk_val [5];
  logic        lk_rdy [5];

  assign lk_msg[0]  = c_in_msg;
  assign lk_val[0]  = c_in_val;
  assign c_in_rdy   = lk_rdy[0];
  assign c_out_msg  = lk_msg[4];
  assign c_out_val  = lk_val[4];
  assign lk_rdy[4]  = c_out_rdy;

  for (genvar g = 0; g < 4; g++) begin : g_chain
    fft_stage_stream #(.BIT_WIDTH(BW), .DECIMAL_PT(16), .N_SAMPLES(16), .STAGE_FFT(g)) u_st (
      .clk(clk), .reset(rst), .recv_msg(lk_msg[g]), .recv_val(lk_val[g]), .recv_rdy(lk_rdy[g]),
      .send_msg(lk_msg[g+1]), .send_val(lk_val[g+1]), .send_rdy(lk_rdy[g+1]), .sine_wave_in(sine16));
  end

  logic [63:0] frm   [8];
  logic [63:0] out_a [8];
  logic [63:0] out_b [8];
  logic [63:0] ea    [8];
  logic [63:0] eb    [8];
  logic [31:0] tab8  [8] = '{32'h0, 32'h0000B505, 32'h00010000, 32'h0000B505,
                             32'h0, 32'hFFFF4AFB, 32'hFFFF0000, 32'hFFFF4AFB};
  logic [31:0] tw16  [16];
  logic [63:0] mbuf  [16];
  logic [63:0] chain_in  [$];
  logic [63:0] chain_exp [$];

  localparam logic [63:0] IMP = 64'h00010000_00000000;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_frames();
    for (int i = 0; i < 8; i++) begin
      frm[i] = '0;
      ea[i]  = '0;
      eb[i]  = '0;
    end
  endtask

  // Offer frm[0..n-1] on the shared input; call in the low clock phase.
  task automatic send8(input int n);
    int tmo;
    tmo = 0;
    for (int i = 0; i < n; i++) begin
      int guard;
      in_msg = frm[i];
      in_val = 1'b1;
      guard  = 0;
      while (!rdy_a && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 100) tmo++;
      @(negedge clk);
    end
    in_val = 1'b0;
    in_msg = '0;
    check("load_timeouts", 64'(tmo), 64'd0);
  endtask

  // Cycles from the negedge after the last accept to the first valid output.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!val_a && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Collect one frame from both N=8 instances; bp selects the 1,0,0,1 ready pattern.
  task automatic recv8(input bit bp);
    int cnt, cyc, hold_err, rdy_err;
    bit prev_stall;
    logic [63:0] prev_a, prev_b;
    logic [3:0] pat;
    pat = 4'b1001;
    cnt = 0; cyc = 0; hold_err = 0; rdy_err = 0;
    prev_stall = 1'b0; prev_a = '0; prev_b = '0;
    while (cnt < 8 && cyc < 200) begin
      send_rdy = bp ? pat[3 - (cyc % 4)] : 1'b1;
      if (prev_stall && (msg_a !== prev_a || msg_b !== prev_b)) hold_err++;
      if (rdy_a || rdy_b) rdy_err++;
      if (val_a && send_rdy) begin
        out_a[cnt] = msg_a;
        out_b[cnt] = msg_b;
        cnt++;
      end
      prev_stall = val_a && !send_rdy;
      prev_a = msg_a;
      prev_b = msg_b;
      @(negedge clk);
      cyc++;
    end
    send_rdy = 1'b0;
    check("drain_count", 64'(cnt), 64'd8);
    check("drain_hold", 64'(hold_err), 64'd0);
    check("drain_rdy_low", 64'(rdy_err), 64'd0);
    check("rdy_after_drain", {62'd0, rdy_a, rdy_b}, 64'd3);
  endtask

  task automatic check_frame(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_s0[%0d]", tag, i), out_a[i], ea[i]);
      check($sformatf("%s_s2[%0d]", tag, i), out_b[i], eb[i]);
    end
  endtask

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    longint pa, pb, p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = (pa * pb) >>> 16;
    return p[31:0];
  endfunction

  // Reference N=16 butterfly stage on mbuf, walked group by group.
  task automatic model_stage(input int s);
    int m;
    m = 1 << s;
    for (int g = 0; g < 16; g += 2 * m) begin
      for (int k = 0; k < m; k++) begin
        int top, bot, t;
        logic [31:0] sn, cs, ar, ai, br, bi, pr, pim;
        top = g + k;
        bot = top + m;
        t   = k * (16 / (2 * m));
        sn  = tw16[t];
        cs  = tw16[(t + 4) % 16];
        ar  = mbuf[top][63:32]; ai = mbuf[top][31:0];
        br  = mbuf[bot][63:32]; bi = mbuf[bot][31:0];
        pr  = fmul(br, cs) + fmul(bi, sn);
        pim = fmul(bi, cs) - fmul(br, sn);
        mbuf[top] = {ar + pr, ai + pim};
        mbuf[bot] = {ar - pr, ai - pim};
      end
    end
  endtask

  task automatic drive_chain();
    int idx, guard;
    bit acc;
    idx = 0; guard = 0;
    while (idx < chain_in.size() && guard < 5000) begin
      c_in_val = ($urandom_range(0, 3) != 0);
      c_in_msg = c_in_val ? chain_in[idx] : 64'hDEAD_BEEF_0BAD_F00D;
      acc = c_in_val && c_in_rdy;
      @(negedge clk);
      if (acc) idx++;
      guard++;
    end
    c_in_val = 1'b0;
    c_in_msg = '0;
    check("chain_in_count", 64'(idx), 64'(chain_in.size()));
  endtask

  task automatic watch_chain();
    int oidx, guard;
    oidx = 0; guard = 0;
    while (oidx < chain_exp.size() && guard < 5000) begin
      c_out_rdy = ($urandom_range(0, 3) != 0);
      if (c_out_val && c_out_rdy) begin
        check($sformatf("chain[%0d]", oidx), c_out_msg, chain_exp[oidx]);
        oidx++;
      end
      @(negedge clk);
      guard++;
    end
    c_out_rdy = 1'b0;
    check("chain_out_count", 64'(oidx), 64'(chain_exp.size()));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    for (int i = 0; i < 8; i++) sine8[32*i +: 32] = tab8[i];
    for (int i = 0; i < 16; i++) begin
      real x;
      x = $sin(2.0 * 3.14159265358979 * i / 16.0) * 65536.0;
      tw16[i] = 32'($rtoi(x >= 0.0 ? x + 0.5 : x - 0.5));
      sine16[32*i +: 32] = tw16[i];
    end
    rst = 1'b1; in_val = 1'b0; in_msg = '0; send_rdy = 1'b0;
    c_in_val = 1'b0; c_in_msg = '0; c_out_rdy = 1'b0;

    // Reset state, sampled while reset is still high.
    @(posedge clk);
    @(negedge clk);
    check("rst_recv_rdy", {62'd0, rdy_a, rdy_b}, 64'd0);
    check("rst_send_val", {62'd0, val_a, val_b}, 64'd0);
    check("rst_send_msg", msg_a | msg_b, 64'd0);
    check("rst_chain", {62'd0, c_in_rdy, c_out_val}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rdy_after_rst", {62'd0, rdy_a, rdy_b}, 64'd3);

    // Impulse at x[0].
    clear_frames();
    frm[0] = IMP;
    ea[0] = IMP; ea[1] = IMP;
    eb[0] = IMP; eb[4] = IMP;
    send8(8);
    wait_out(lat);
    check("latency", 64'(lat), 64'd4);
    recv8(1'b0);
    check_frame("imp0");

    // Impulse at x[5] exercises a non-trivial twiddle in stage 2; with backpressure.
    clear_frames();
    frm[5] = IMP;
    ea[4] = 64'h00010000_00000000; ea[5] = 64'hFFFF0000_00000000;
    eb[1] = 64'h0000B505_FFFF4AFB; eb[5] = 64'hFFFF4AFB_0000B505;
    send8(8);
    wait_out(lat);
    check("latency_bp", 64'(lat), 64'd4);
    recv8(1'b1);
    check_frame("imp5");

    // Floor rounding of -0.707 LSB.
    clear_frames();
    frm[5] = 64'hFFFFFFFF_00000000;
    ea[4] = 64'hFFFFFFFF_00000000; ea[5] = 64'h00000001_00000000;
    eb[1] = 64'hFFFFFFFF_00000001; eb[5] = 64'h00000001_FFFFFFFF;
    send8(8);
    wait_out(lat);
    recv8(1'b0);
    check_frame("floor");

    // Reset after three loaded samples, then a fresh frame.
    for (int i = 0; i < 8; i++) frm[i] = 64'h00012345_00000777;
    send8(3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midload_rdy", {62'd0, rdy_a, rdy_b}, 64'd3);
    clear_frames();
    frm[2] = 64'h00010000_00020000;
    ea[2] = frm[2]; ea[3] = frm[2];
    eb[2] = frm[2]; eb[6] = frm[2];
    send8(8);
    wait_out(lat);
    recv8(1'b0);
    check_frame("fresh");

    // Reset during DRAIN after one sample has left.
    clear_frames();
    frm[3] = IMP;
    send8(8);
    wait_out(lat);
    send_rdy = 1'b1;
    @(negedge clk);
    send_rdy = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("drain_rst_val", {62'd0, val_a, val_b}, 64'd0);
    check("drain_rst_msg", msg_a | msg_b, 64'd0);
    rst = 1'b0;
    #1;
    check("drain_rst_rdy", {62'd0, rdy_a, rdy_b}, 64'd3);
    clear_frames();
    frm[0] = IMP;
    ea[0] = IMP; ea[1] = IMP;
    eb[0] = IMP; eb[4] = IMP;
    send8(8);
    wait_out(lat);
    recv8(1'b1);
    check_frame("after_drain_rst");

    // Back-to-back random frames through the N=16 cascade.
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < 16; i++) begin
        mbuf[i] = {$urandom(), $urandom()};
        chain_in.push_back(mbuf[i]);
      end
      for (int s = 0; s < 4; s++) model_stage(s);
      for (int i = 0; i < 16; i++) chain_exp.push_back(mbuf[i]);
    end
    @(negedge clk);
    fork
      drive_chain();
      watch_chain();
    join
    repeat (5) @(negedge clk);
    check("chain_no_extra", {63'd0, c_out_val}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
